// File: rtl/snake_pkg.sv
// Shared types for the snake direction input path: direction encoding,
// reversal helper and turn-queue depth.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    localparam int unsigned TURN_QUEUE_DEPTH = 2;

    // Opposite direction differs only in the LSB.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_dir_input_debounce.sv
// One-button conditioner: 2-flop synchroniser, inversion to active-high,
// and a counter-based debouncer producing a stable pressed level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    logic             sync_a;
    logic             sync_b;
    logic             pressed_c;
    logic [CNT_W-1:0] count;

    assign pressed_c = ~sync_b;

    // Idle-high synchroniser so reset looks like a released button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (pressed_c == stable) begin
            count <= '0;
        end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= pressed_c;
            count  <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/snake_dir_input.sv
// Button-to-direction front end: debounces four buttons, queues turn requests
// and applies one per move_tick. Optional macro: SNAKE_REVERSE_GUARD_EN.
module snake_dir_input
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       move_tick,
    output dir_t       dir,
    output logic       dir_changed,
    output logic [1:0] pending,
    output logic [3:0] led
);

    // Button index doubles as press priority: 0=up, 1=down, 2=left, 3=right.
    logic [3:0] stable;
    logic [3:0] stable_q;
    logic [3:0] rise;

    dir_t       slot0_q;
    dir_t       slot1_q;
    dir_t       slot0_n;
    dir_t       slot1_n;
    dir_t       dir_n;
    dir_t       press;
    dir_t       ref_dir;
    logic       changed_n;
    logic       accept;
    logic [1:0] count_n;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
        .clk(clk), .reset(reset), .raw(up_button), .stable(stable[0])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
        .clk(clk), .reset(reset), .raw(down_button), .stable(stable[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
        .clk(clk), .reset(reset), .raw(left_button), .stable(stable[2])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
        .clk(clk), .reset(reset), .raw(right_button), .stable(stable[3])
    );

    assign led  = {stable[2], stable[0], stable[1], stable[3]};
    assign rise = stable & ~stable_q;

    // Pop first, then judge the press against the post-pop tail (or new dir).
    always_comb begin
        dir_n     = dir;
        changed_n = 1'b0;
        slot0_n   = slot0_q;
        slot1_n   = slot1_q;
        count_n   = pending;
        press     = DIR_RIGHT;

        if (rise[0]) begin
            press = DIR_UP;
        end else if (rise[1]) begin
            press = DIR_DOWN;
        end else if (rise[2]) begin
            press = DIR_LEFT;
        end

        if (move_tick && (pending != 2'd0)) begin
            dir_n     = slot0_q;
            changed_n = 1'b1;
            slot0_n   = slot1_q;
            count_n   = pending - 2'd1;
        end

        if (count_n == 2'd0) begin
            ref_dir = dir_n;
        end else if (count_n == 2'd1) begin
            ref_dir = slot0_n;
        end else begin
            ref_dir = slot1_n;
        end

        accept = (|rise) && (press != ref_dir) && (count_n < 2'(TURN_QUEUE_DEPTH));
`ifdef SNAKE_REVERSE_GUARD_EN
        accept = accept && (press != dir_reverse(ref_dir));
`endif

        if (accept) begin
            if (count_n == 2'd0) begin
                slot0_n = press;
            end else begin
                slot1_n = press;
            end
            count_n = count_n + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir         <= DIR_RIGHT;
            dir_changed <= 1'b0;
            pending     <= 2'd0;
            slot0_q     <= DIR_RIGHT;
            slot1_q     <= DIR_RIGHT;
            stable_q    <= 4'd0;
        end else begin
            dir         <= dir_n;
            dir_changed <= changed_n;
            pending     <= count_n;
            slot0_q     <= slot0_n;
            slot1_q     <= slot1_n;
            stable_q    <= stable;
        end
    end

endmodule
